// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC grid: FSM state type, default
// geometry/width constants and the saturating accumulate helper.
// No ports; imported by systolic_pe and systolic_mac_grid.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_K_W    = 8;

  // Adds two sign-extended values and clamps the result to a signed w-bit
  // range. Operands are carried at 64 bits so one helper serves any ACC_W
  // up to 63; the extra sum bit makes the overflow test exact.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = {a[63], a} + {b[63], b};
    hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (w - 1));
    if (sum > hi)      return hi[63:0];
    else if (sum < lo) return lo[63:0];
    else               return sum[63:0];
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: registers and forwards a (east) and b (south), accumulates a*b.
// Latency: operands forwarded one cycle later; product lands in acc on the same edge.
// Backpressure: none; runs every cycle, zero operands are harmless.
// Ports: clk/rst_n (async active-low), clear (synchronous wipe), a_west/b_north
// operand inputs, a_east/b_south forwarded operands, acc accumulator.
// SYSTOLIC_SAT_EN: saturate acc instead of wrapping modulo 2^ACC_W.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] a_west,
  input  logic signed [DATA_W-1:0] b_north,
  output logic signed [DATA_W-1:0] a_east,
  output logic signed [DATA_W-1:0] b_south,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_next;

  assign prod = a_west * b_north;

`ifdef SYSTOLIC_SAT_EN
  assign acc_next = ACC_W'(sat_add(64'(acc), 64'(prod), ACC_W));
`else
  // Signed size cast sign-extends the product before the wrapping add.
  assign acc_next = acc + ACC_W'(prod);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_east  <= '0;
      b_south <= '0;
      acc     <= '0;
    end else if (clear) begin
      a_east  <= '0;
      b_south <= '0;
      acc     <= '0;
    end else begin
      a_east  <= a_west;
      b_south <= b_north;
      acc     <= acc_next;
    end
  end

endmodule

// File: rtl/systolic_mac_grid.sv
// ROWS x COLS output-stationary systolic MAC grid with input skew, job FSM and readout.
// Latency: done arrives ROWS+COLS cycles after the edge accepting the last beat; readout 1 cycle.
// Backpressure: in_ready high only in RUN; idle cycles inject zero operands.
// Ports: master_clock, reset_n (async active-low), start/k_len job launch,
// in_valid/in_ready beat handshake, x_input_array/y_input_array packed operands,
// busy/done status, rdn/x_position/y_position/output_value accumulator readout.
// SYSTOLIC_SAT_EN: saturating accumulation (otherwise wrap).
module systolic_mac_grid
  import systolic_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_W    = DEF_K_W
) (
  input  logic                     master_clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [K_W-1:0]           k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   x_input_array,
  input  logic [COLS*DATA_W-1:0]   y_input_array,
  output logic                     busy,
  output logic                     done,
  input  logic                     rdn,
  input  logic [7:0]               x_position,
  input  logic [7:0]               y_position,
  output logic [ACC_W-1:0]         output_value
);

  // Last operand pair reaches PE(ROWS-1,COLS-1) ROWS+COLS-2 edges after it is accepted.
  localparam int FLUSH_LEN = ROWS + COLS - 1;

  state_t         state;
  logic [K_W-1:0] beats_left;
  logic [5:0]     flush_cnt;
  logic           accept;
  logic           clear;

  assign accept = in_valid && in_ready;
  assign clear  = start && (state == IDLE);

  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      beats_left <= '0;
      flush_cnt  <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (k_len == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= RUN;
            beats_left <= k_len;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN: if (accept) begin
          if (beats_left == K_W'(1)) begin
            state     <= FLUSH;
            in_ready  <= 1'b0;
            flush_cnt <= 6'(FLUSH_LEN - 1);
          end else begin
            beats_left <= beats_left - K_W'(1);
          end
        end
        FLUSH: if (flush_cnt == '0) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          flush_cnt <= flush_cnt - 6'(1);
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand lanes: zero whenever no beat is accepted.
  logic signed [DATA_W-1:0] x_beat [ROWS];
  logic signed [DATA_W-1:0] y_beat [COLS];
  logic signed [DATA_W-1:0] x_edge [ROWS];
  logic signed [DATA_W-1:0] y_edge [COLS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) x_beat[r] = accept ? x_input_array[r*DATA_W +: DATA_W] : '0;
    for (int c = 0; c < COLS; c++) y_beat[c] = accept ? y_input_array[c*DATA_W +: DATA_W] : '0;
  end

  // Skew: row r / column c pass through r / c delay stages so beat k meets
  // itself at PE(r,c) exactly r+c cycles after acceptance.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_xskew
    if (gr == 0) begin : g_pass
      assign x_edge[0] = x_beat[0];
    end else begin : g_dly
      logic signed [DATA_W-1:0] dly [gr];
      always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n || clear) begin
          for (int j = 0; j < gr; j++) dly[j] <= '0;
        end else begin
          dly[0] <= x_beat[gr];
          for (int j = 1; j < gr; j++) dly[j] <= dly[j-1];
        end
      end
      assign x_edge[gr] = dly[gr-1];
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_yskew
    if (gc == 0) begin : g_pass
      assign y_edge[0] = y_beat[0];
    end else begin : g_dly
      logic signed [DATA_W-1:0] dly [gc];
      always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n || clear) begin
          for (int j = 0; j < gc; j++) dly[j] <= '0;
        end else begin
          dly[0] <= y_beat[gc];
          for (int j = 1; j < gc; j++) dly[j] <= dly[j-1];
        end
      end
      assign y_edge[gc] = dly[gc-1];
    end
  end

  logic signed [DATA_W-1:0] a_fwd    [ROWS][COLS];
  logic signed [DATA_W-1:0] b_fwd    [ROWS][COLS];
  logic signed [ACC_W-1:0]  acc_grid [ROWS][COLS];

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic signed [DATA_W-1:0] a_src;
      logic signed [DATA_W-1:0] b_src;
      if (gc == 0) begin : g_aw
        assign a_src = x_edge[gr];
      end else begin : g_aw
        assign a_src = a_fwd[gr][gc-1];
      end
      if (gr == 0) begin : g_bn
        assign b_src = y_edge[gc];
      end else begin : g_bn
        assign b_src = b_fwd[gr-1][gc];
      end
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk     (master_clock),
        .rst_n   (reset_n),
        .clear   (clear),
        .a_west  (a_src),
        .b_north (b_src),
        .a_east  (a_fwd[gr][gc]),
        .b_south (b_fwd[gr][gc]),
        .acc     (acc_grid[gr][gc])
      );
    end
  end

  // The east column and south row outputs leave the grid unconsumed.
  logic unused_fwd;
  always_comb begin
    unused_fwd = 1'b0;
    for (int r = 0; r < ROWS; r++) unused_fwd = unused_fwd ^ (^a_fwd[r][COLS-1]);
    for (int c = 0; c < COLS; c++) unused_fwd = unused_fwd ^ (^b_fwd[ROWS-1][c]);
  end

  // Full-width compare on the position makes out-of-range reads fall through to zero.
  logic [ACC_W-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (x_position == 8'(r) && y_position == 8'(c)) rd_val = acc_grid[r][c];
  end

  always_ff @(posedge master_clock or negedge reset_n) begin
    if (!reset_n)  output_value <= '0;
    else if (!rdn) output_value <= rd_val;
  end

endmodule

// File: tb/tb_systolic_mac_grid.sv
// Self-checking bench for systolic_mac_grid (4x4, 8-bit operands, 16-bit accumulators).
// Expected sums come from a matrix-product model over the accepted beats;
// honours SYSTOLIC_SAT_EN when the build defines it.
module tb_systolic_mac_grid;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int K_W    = 8;
  localparam int KMAX   = 16;
  localparam int SMAX   = (1 << (ACC_W - 1)) - 1;
  localparam int SMIN   = -(1 << (ACC_W - 1));

  logic                   master_clock = 1'b0;
  logic                   reset_n      = 1'b0;
  logic                   start        = 1'b0;
  logic [K_W-1:0]         k_len        = '0;
  logic                   in_valid     = 1'b0;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] x_input_array = '0;
  logic [COLS*DATA_W-1:0] y_input_array = '0;
  logic                   busy;
  logic                   done;
  logic                   rdn          = 1'b1;
  logic [7:0]             x_position   = '0;
  logic [7:0]             y_position   = '0;
  logic [ACC_W-1:0]       output_value;

  int n_checks = 0;
  int n_errors = 0;
  int bx [KMAX][ROWS];
  int by [KMAX][COLS];

  always #5 master_clock = ~master_clock;

  systolic_mac_grid #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .master_clock  (master_clock),
    .reset_n       (reset_n),
    .start         (start),
    .k_len         (k_len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .x_input_array (x_input_array),
    .y_input_array (y_input_array),
    .busy          (busy),
    .done          (done),
    .rdn           (rdn),
    .x_position    (x_position),
    .y_position    (y_position),
    .output_value  (output_value)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // C[r][c] = sum_k x[k][r] * y[k][c], reduced to ACC_W bits.
  function automatic logic [ACC_W-1:0] model(input int r, input int c, input int k);
    int acc = 0;
    for (int i = 0; i < k; i++) begin
      acc += bx[i][r] * by[i][c];
`ifdef SYSTOLIC_SAT_EN
      if (acc > SMAX) acc = SMAX;
      else if (acc < SMIN) acc = SMIN;
`endif
    end
    return ACC_W'(acc);
  endfunction

  task automatic fill_random(input int k);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < ROWS; r++) bx[i][r] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < COLS; c++) by[i][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // mode 0: valid every cycle, 1: alternate cycles, 2: random gaps.
  // poke re-asserts start mid-RUN with a different k_len, which must be ignored.
  task automatic send_beats(input int k, input int mode, input bit poke);
    int sent = 0;
    int cyc  = 0;
    @(negedge master_clock);
    start = 1'b1;
    k_len = K_W'(k);
    @(negedge master_clock);
    start = 1'b0;
    k_len = K_W'($urandom_range(1, 255));
    check("run_busy", 32'(busy), 32'(1));
    while (sent < k && cyc < 300) begin
      bit v;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      for (int r = 0; r < ROWS; r++)
        x_input_array[r*DATA_W +: DATA_W] = v ? DATA_W'(bx[sent][r]) : DATA_W'($urandom);
      for (int c = 0; c < COLS; c++)
        y_input_array[c*DATA_W +: DATA_W] = v ? DATA_W'(by[sent][c]) : DATA_W'($urandom);
      if (poke && cyc == 1) begin
        start = 1'b1;
        k_len = K_W'(k + 3);
      end
      if (v && in_ready) sent++;
      @(negedge master_clock);
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    check("beats_accepted", 32'(sent), 32'(k));
  endtask

  task automatic wait_done(input string tag);
    int lat = 1;
    check({tag, "_ready_low"}, 32'(in_ready), 32'(0));
    check({tag, "_flush_busy"}, 32'(busy), 32'(1));
    while (!done && lat < 100) begin
      @(negedge master_clock);
      lat++;
    end
    check({tag, "_done_latency"}, 32'(lat), 32'(ROWS + COLS));
    check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    @(negedge master_clock);
    check({tag, "_done_one_cycle"}, 32'(done), 32'(0));
  endtask

  task automatic rd(input int r, input int c, input bit strobe, input logic [ACC_W-1:0] exp, input string tag);
    rdn        = !strobe;
    x_position = 8'(r);
    y_position = 8'(c);
    @(negedge master_clock);
    check(tag, 32'(output_value), 32'(exp));
    rdn = 1'b1;
  endtask

  task automatic verify_all(input string tag, input int k);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        rd(r, c, 1'b1, model(r, c, k), $sformatf("%s_pe_%0d_%0d", tag, r, c));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int done_seen;
    logic [ACC_W-1:0] hold_val;

    #2;
    check("reset_in_ready", 32'(in_ready), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_output", 32'(output_value), 32'(0));
    @(negedge master_clock);
    @(negedge master_clock);
    reset_n = 1'b1;

    // Uniform operands, gap-free: 5 * 3 * 2 = 30 everywhere.
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < ROWS; r++) bx[i][r] = 3;
      for (int c = 0; c < COLS; c++) by[i][c] = 2;
    end
    send_beats(5, 0, 1'b0);
    wait_done("uniform");
    verify_all("uniform", 5);
    rd(3, 3, 1'b1, ACC_W'(30), "uniform_corner_30");

    // Alternate-cycle gaps: x = 1,2,3 per beat, y = 1 -> 6 everywhere.
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < ROWS; r++) bx[i][r] = i + 1;
      for (int c = 0; c < COLS; c++) by[i][c] = 1;
    end
    send_beats(3, 1, 1'b0);
    wait_done("gapped");
    verify_all("gapped", 3);
    rd(2, 1, 1'b1, ACC_W'(6), "gapped_six");

    // Most-negative operands overflow a 16-bit accumulator after two beats.
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < ROWS; r++) bx[i][r] = -128;
      for (int c = 0; c < COLS; c++) by[i][c] = -128;
    end
    send_beats(2, 2, 1'b0);
    wait_done("signed");
    verify_all("signed", 2);
`ifdef SYSTOLIC_SAT_EN
    rd(0, 0, 1'b1, 16'h7fff, "signed_saturate");
`else
    rd(0, 0, 1'b1, 16'h8000, "signed_wrap");
`endif

    // Out-of-range reads return zero; rdn high holds the last value.
    rd(9, 0, 1'b1, '0, "oob_row");
    rd(1, 4, 1'b1, '0, "oob_col");
    hold_val = model(3, 3, 2);
    rd(3, 3, 1'b1, hold_val, "hold_load");
    rd(1, 9, 1'b0, hold_val, "hold_rdn_high");

    // Zero-length job: done next cycle, grid cleared.
    start = 1'b1;
    k_len = '0;
    @(negedge master_clock);
    start = 1'b0;
    check("k0_done", 32'(done), 32'(1));
    check("k0_busy", 32'(busy), 32'(0));
    check("k0_ready", 32'(in_ready), 32'(0));
    @(negedge master_clock);
    check("k0_done_cleared", 32'(done), 32'(0));
    verify_all("k0", 0);

    // Reset during FLUSH abandons the job.
    fill_random(4);
    send_beats(4, 0, 1'b0);
    rd(0, 0, 1'b1, model(0, 0, 4), "flush_partial_read");
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_ready", 32'(in_ready), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_output", 32'(output_value), 32'(0));
    @(negedge master_clock);
    reset_n   = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge master_clock);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'(0));
    verify_all("abort", 0);

    // Randomized jobs with random gaps and occasional ignored mid-run start.
    for (int j = 0; j < 6; j++) begin
      k = int'($urandom_range(1, KMAX));
      fill_random(k);
      send_beats(k, 2, 1'($urandom_range(0, 1)));
      wait_done($sformatf("rand%0d", j));
      verify_all($sformatf("rand%0d", j), k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
